// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the 16-bit program counter, issues instruction-memory
// requests, presents fetched instructions to IF/ID and redirects on taken
// branches (PCSRC=0). A one-entry hold buffer absorbs a response that
// arrives while IF/ID is stalled. DRAIN waits out an outstanding request
// whose data must be discarded after a redirect.
module pc_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          INSTR_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               branch,
  input  logic               PCSRC,
  input  logic [15:0]        branch_target,
  input  logic               stall,
  output logic               imem_req,
  output logic [15:0]        imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [15:0]        if_pc,
  output logic               flush
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t             state_r;
  logic [15:0]        pc_r;
  logic [15:0]        drain_tgt_r;
  logic [INSTR_W-1:0] hold_instr_r;
  logic [15:0]        hold_pc_r;
  logic               imem_req_r;
  logic               if_valid_r;
  logic [INSTR_W-1:0] if_instr_r;
  logic [15:0]        if_pc_r;
  logic               flush_r;

  logic               redirect_s;
  logic [15:0]        target_s;
  logic [15:0]        pc_inc_s;

  // Redirect decode; odd targets are forced even, pc+2 wraps modulo 2^16.
  always_comb begin
    redirect_s = branch & ~PCSRC;
    target_s   = branch_target & 16'hFFFE;
    pc_inc_s   = pc_r + 16'd2;
  end

  // Fetch FSM: PC, hold buffer, drain target and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      pc_r         <= RESET_PC;
      drain_tgt_r  <= 16'h0000;
      hold_instr_r <= '0;
      hold_pc_r    <= 16'h0000;
      imem_req_r   <= 1'b0;
      if_valid_r   <= 1'b0;
      if_instr_r   <= '0;
      if_pc_r      <= 16'h0000;
      flush_r      <= 1'b0;
    end else begin
      // flush pulses for exactly the cycle after every redirect edge
      flush_r <= redirect_s;
      case (state_r)
        IDLE: begin
          state_r    <= FETCH;
          imem_req_r <= 1'b1;
          if (redirect_s) begin
            pc_r       <= target_s;
            if_valid_r <= 1'b0;
          end else if (!stall) begin
            if_valid_r <= 1'b0;
          end
        end
        FETCH: begin
          if (redirect_s) begin
            if_valid_r <= 1'b0;
            imem_req_r <= 1'b1;
            if (imem_ready) begin
              // request just completed: its data is dropped, go straight on
              pc_r    <= target_s;
              state_r <= FETCH;
            end else begin
              // request still outstanding: keep the address until it returns
              drain_tgt_r <= target_s;
              state_r     <= DRAIN;
            end
          end else if (imem_ready) begin
            pc_r <= pc_inc_s;
            if (stall) begin
              hold_instr_r <= imem_rdata;
              hold_pc_r    <= pc_r;
              imem_req_r   <= 1'b0;
              state_r      <= HOLD;
            end else begin
              if_instr_r <= imem_rdata;
              if_pc_r    <= pc_r;
              if_valid_r <= 1'b1;
            end
          end else if (!stall) begin
            if_valid_r <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect_s) begin
            pc_r       <= target_s;
            if_valid_r <= 1'b0;
            imem_req_r <= 1'b1;
            state_r    <= FETCH;
          end else if (!stall) begin
            if_instr_r <= hold_instr_r;
            if_pc_r    <= hold_pc_r;
            if_valid_r <= 1'b1;
            imem_req_r <= 1'b1;
            state_r    <= FETCH;
          end
        end
        DRAIN: begin
          if (redirect_s) begin
            // newest redirect wins over the latched target
            if_valid_r <= 1'b0;
            if (imem_ready) begin
              pc_r    <= target_s;
              state_r <= FETCH;
            end else begin
              drain_tgt_r <= target_s;
            end
          end else if (imem_ready) begin
            pc_r    <= drain_tgt_r;
            state_r <= FETCH;
            if (!stall) begin
              if_valid_r <= 1'b0;
            end
          end else if (!stall) begin
            if_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= IDLE;
          imem_req_r <= 1'b0;
          if_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = imem_req_r;
  assign imem_addr = pc_r;
  assign if_valid  = if_valid_r;
  assign if_instr  = if_instr_r;
  assign if_pc     = if_pc_r;
  assign flush     = flush_r;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Fetch-side consumer of the branch decision: owns the 16-bit program counter and issues instruction-memory requests.
- Presents fetched instructions to the IF/ID stage.
- Redirects to the branch target when the branch comparator signals a taken branch.
- Sits between the branch logic and instruction memory in the 16-bit datapath.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset; bit 0 must be 0.
- INSTR_W, 16, instruction width in bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- branch  input  1  a branch instruction is resolving this cycle.
- PCSRC  input  1  branch comparator result; 0 = take target, 1 = sequential (PC+2).
- branch_target  input  16  redirect address.
- stall  input  1  IF/ID stage cannot accept a new instruction.
- imem_req  output  1  instruction memory request valid.
- imem_addr  output  16  instruction memory byte address.
- imem_ready  input  1  memory returns data this cycle; only meaningful while imem_req=1.
- imem_rdata  input  INSTR_W  instruction data, valid when imem_req and imem_ready are both 1.
- if_valid  output  1  if_instr/if_pc hold a live instruction.
- if_instr  output  INSTR_W  fetched instruction.
- if_pc  output  16  address of if_instr.
- flush  output  1  one-cycle pulse; downstream discards younger instructions.

Behaviour:
- Reset, with rst=1 at a clock edge:
  - pc=RESET_PC; state=IDLE.
  - imem_req=0, if_valid=0, if_instr=0, if_pc=0, flush=0.
  - Hold buffer empty; pending-redirect flag cleared.
  - Reset overrides every other input, including mid-transaction; any in-flight memory response is ignored.
- States: IDLE, FETCH, HOLD, DRAIN.
- IDLE: lasts one cycle after reset is released, then moves to FETCH.
- Memory protocol:
  - imem_req=1 and imem_addr=pc in FETCH and DRAIN only.
  - imem_addr must stay stable while imem_req=1 and imem_ready=0.
  - The transfer completes in the cycle where imem_ready=1.
- FETCH, no redirect, ready=1, stall=0:
  - if_instr<=imem_rdata, if_pc<=pc, if_valid<=1.
  - pc<=pc+2; remain in FETCH.
  - Throughput is one instruction per cycle when ready is held at 1.
- FETCH, ready=1, stall=1:
  - Capture rdata and pc into the hold buffer.
  - pc<=pc+2; move to HOLD (imem_req=0).
  - IF/ID outputs keep their values.
- FETCH, ready=0: no change; if stall=1, IF/ID outputs hold.
- HOLD, stall=0: load IF/ID from the hold buffer, if_valid<=1, return to FETCH.
- Stall rules:
  - While stall=1, if_valid, if_instr and if_pc never change, except on a redirect.
  - While stall=0 and no instruction is delivered, if_valid<=0.
- Redirect:
  - Condition: branch=1 and PCSRC=0 at a clock edge.
  - branch=1 with PCSRC=1, or branch=0: no effect.
- Redirect effects, at the same edge:
  - if_valid<=0; flush=1 for exactly the next cycle.
  - Hold buffer cleared.
  - target = {branch_target[15:1],1'b0}, i.e. odd targets are forced even.
  - Redirect takes priority over stall and over a same-cycle ready; that cycle's rdata is discarded.
- Redirect when no request is outstanding (HOLD, IDLE, FETCH with ready=1):
  - pc<=target; go to FETCH.
  - imem_addr=target in the next cycle.
- Redirect in FETCH with ready=0 (request outstanding):
  - Latch target; go to DRAIN; imem_addr keeps the old pc.
- DRAIN:
  - On ready=1: drop rdata, pc<=latched target, go to FETCH.
  - A further redirect while in DRAIN overwrites the latched target (newest wins) and re-pulses flush.
- Arithmetic: pc+2 is modulo 2^16, so 16'hFFFE wraps to 16'h0000 with no flag.
- Latency:
  - Request-to-output is 1 cycle from the ready edge.
  - Redirect-to-new-address is 1 cycle, or memory latency +1 when draining.

Test Plan:
- Reset, ready=1, stall=0 → imem_req=0 for the reset cycle and the IDLE cycle, then addresses 0000, 0002, 0004; if_pc follows one cycle later with if_valid=1.
- Stall held for 3 cycles while ready=1 at pc=0004 → if_pc stays at the prior value; imem_req=0 in HOLD; after stall drops, if_pc=0004 and the next imem_addr=0006.
- branch=1, PCSRC=0, branch_target=0041 at pc=0008 → flush=1 for one cycle, if_valid=0, next imem_addr=0040, then if_pc=0040.
- branch=1, PCSRC=1, target=0100 → no flush; sequential fetch continues at pc+2.
- Redirect to 0200 while ready=0 at addr 000C → addr stays 000C until ready; that rdata is not delivered; next addr=0200. A second redirect to 0300 during the drain gives next addr=0300.
- Redirect to FFFE with ready=1 → fetches FFFE then 0000. Assert rst mid-DRAIN → all outputs return to reset values and fetch restarts at RESET_PC.
